data_mem: RTL and testbench
===========================

Name: data_mem

Overview:
- Memory (DM) pipeline stage of the 8-bit pipelined processor, between the execute (EX) and writeback stages.
- Holds a 256 x 8 data memory addressed by the EX-stage ALU result.
- Stores the bypassed B operand on writes.
- Registers either the memory read data or the ALU result, plus the destination register index, into the DM/WB pipeline register.

Parameters:
- DATA_W, 8, data/ALU width.
- ADDR_W, 8, memory address width (ALU result used as address).
- DEPTH, 256 (2**ADDR_W), memory words.
- REG_W, 5, register-file index width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- ans_ex  input  DATA_W  EX-stage ALU result; memory address and pass-through result.
- B_Bypass  input  DATA_W  store data (forwarded B operand).
- RW_ex  input  REG_W  destination register index from EX.
- mem_en_ex  input  1  memory enable; 0 = no access, read data forced to 0.
- mem_rw_ex  input  1  1 = write, 0 = read (valid only when mem_en_ex=1).
- mem_mux_sel_ex  input  1  1 = select memory read data, 0 = select ans_ex.
- mux_ans_dm  output  DATA_W  registered stage result to WB.
- RW_dm  output  REG_W  registered destination index to WB.

Behaviour:
- Single clock domain. Reset is synchronous and active-high; it is sampled only on rising clk.
- Reset cycle:
  - mux_ans_dm <= 8'h00 and RW_dm <= 5'h00.
  - All DEPTH memory words are cleared to 8'h00.
  - Any write requested in the same cycle is ignored; reset has priority.
- Read data, combinational and internal:
  - rdata = mem[ans_ex] when mem_en_ex=1 and mem_rw_ex=0.
  - rdata = mem[ans_ex] (pre-write contents) when mem_en_ex=1 and mem_rw_ex=1.
  - rdata = 8'h00 when mem_en_ex=0.
- Write: on a rising edge with reset=0, mem_en_ex=1 and mem_rw_ex=1, mem[ans_ex] <= B_Bypass. No write in any other case.
- Pipeline register, on a rising edge with reset=0:
  - mux_ans_dm <= mem_mux_sel_ex ? rdata : ans_ex.
  - RW_dm <= RW_ex, unconditionally (no stall or flush input).
- Latency: exactly 1 cycle from inputs to outputs.
- Write and read on the same edge: the output captures the old contents. New data is visible one cycle later when a read of that address is presented.
- Memory has no bounds issue: the full 8-bit address space is implemented, so there is no wrap-around logic.
- Reset mid-operation: stored data is lost (memory is cleared) and outputs go to zero on that edge.
- No X propagation: every memory word and register has a defined value after the first reset.

Decomposition:
- Shared package (cpu_pkg): DATA_W, ADDR_W, REG_W constants; optional typedefs data_t (logic [7:0]) and reg_idx_t (logic [4:0]).
- One sub-module, data_mem_ram: DEPTH x DATA_W array with synchronous write, asynchronous read, and synchronous clear on reset.
- The top level, data_mem, holds the enable gating, the result mux and the DM pipeline registers.

Test Plan:
- Reset: assert reset for 1 edge -> mux_ans_dm=8'h00, RW_dm=5'h00; reading any address (e.g. 8'h05, 8'hFF) afterwards returns 8'h00.
- Disabled memory: mem_en_ex=0, mem_mux_sel_ex=1, ans_ex=8'h05, RW_ex=5'h1F -> next edge mux_ans_dm=8'h00, RW_dm=5'h1F.
- Write: mem_en_ex=1, mem_rw_ex=1, ans_ex=8'h05, B_Bypass=8'h50, sel=1 -> that edge outputs the old value 8'h00 and stores mem[5]=8'h50. Then set mem_rw_ex=0 -> next edge mux_ans_dm=8'h50.
- ALU pass-through: mem_en_ex=1, mem_rw_ex=0, sel=0, ans_ex=8'h05 -> mux_ans_dm=8'h05. With ans_ex=8'hA3 and sel=0 -> 8'hA3, independent of memory contents.
- Address isolation: write 8'h11 to 8'h00 and 8'h22 to 8'hFF, then read both with sel=1 -> 8'h11 and 8'h22; 8'h05 still reads 8'h50.
- Reset mid-operation: after mem[5]=8'h50, assert reset during a write of 8'h77 to 8'h05 -> outputs 8'h00, and a subsequent read of 8'h05 returns 8'h00 (neither 8'h50 nor 8'h77).

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared widths and types for the 8-bit pipelined processor.
// Imported by every pipeline stage.
package cpu_pkg;

   localparam int DATA_W = 8;
   localparam int ADDR_W = 8;
   localparam int DEPTH  = 2 ** ADDR_W;
   localparam int REG_W  = 5;

   typedef logic [DATA_W-1:0] data_t;
   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [REG_W-1:0]  reg_idx_t;

   function automatic data_t sel_result(
      input logic  sel,
      input data_t mem_data,
      input data_t alu_data
   );
      return sel ? mem_data : alu_data;
   endfunction

endpackage

// File: rtl/data_mem_ram.sv
// DEPTH x DATA_W data RAM: synchronous write, asynchronous read,
// synchronous clear of every word on reset.
module data_mem_ram
   import cpu_pkg::*;
(
   input  logic  clk,
   input  logic  reset,
   input  logic  we_i,
   input  addr_t addr_i,
   input  data_t wdata_i,
   output data_t rdata_o
);

   data_t mem_q [DEPTH];

   // Reset wins over a write presented on the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/data_mem.sv
// DM pipeline stage: data RAM access, result select and the
// DM/WB pipeline register.
module data_mem
   import cpu_pkg::*;
(
   input  logic     clk,
   input  logic     reset,
   input  data_t    ans_ex,
   input  data_t    B_Bypass,
   input  reg_idx_t RW_ex,
   input  logic     mem_en_ex,
   input  logic     mem_rw_ex,
   input  logic     mem_mux_sel_ex,
   output data_t    mux_ans_dm,
   output reg_idx_t RW_dm
);

   logic     we;
   data_t    ram_rdata;
   data_t    rdata;
   data_t    mux_ans_d;
   data_t    mux_ans_q;
   reg_idx_t rw_d;
   reg_idx_t rw_q;

   assign we = mem_en_ex & mem_rw_ex;

   data_mem_ram u_ram (
      .clk     (clk),
      .reset   (reset),
      .we_i    (we),
      .addr_i  (ans_ex),
      .wdata_i (B_Bypass),
      .rdata_o (ram_rdata)
   );

   // Read data is the pre-write word, so a store returns old contents.
   always_comb begin
      rdata     = '0;
      if (mem_en_ex) begin
         rdata = ram_rdata;
      end
      mux_ans_d = sel_result(mem_mux_sel_ex, rdata, ans_ex);
      rw_d      = RW_ex;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mux_ans_q <= '0;
         rw_q      <= '0;
      end else begin
         mux_ans_q <= mux_ans_d;
         rw_q      <= rw_d;
      end
   end

   assign mux_ans_dm = mux_ans_q;
   assign RW_dm      = rw_q;

endmodule

// File: tb/tb_data_mem.sv
// Scoreboard bench for the DM stage: a reference memory model
// predicts each registered result one cycle ahead.
module tb_data_mem;
   import cpu_pkg::*;

   typedef struct {
      data_t    data;
      reg_idx_t rw;
   } exp_t;

   logic     clk = 1'b0;
   logic     reset = 1'b1;
   data_t    ans_ex = '0;
   data_t    B_Bypass = '0;
   reg_idx_t RW_ex = '0;
   logic     mem_en_ex = 1'b0;
   logic     mem_rw_ex = 1'b0;
   logic     mem_mux_sel_ex = 1'b0;
   data_t    mux_ans_dm;
   reg_idx_t RW_dm;

   int   checks = 0;
   int   failures = 0;
   exp_t sb_q[$];
   data_t model [DEPTH];

   always #5 clk = ~clk;

   data_mem dut (
      .clk            (clk),
      .reset          (reset),
      .ans_ex         (ans_ex),
      .B_Bypass       (B_Bypass),
      .RW_ex          (RW_ex),
      .mem_en_ex      (mem_en_ex),
      .mem_rw_ex      (mem_rw_ex),
      .mem_mux_sel_ex (mem_mux_sel_ex),
      .mux_ans_dm     (mux_ans_dm),
      .RW_dm          (RW_dm)
   );

   task automatic chk(input string tag, input logic [7:0] got,
                      input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step(input string tag, input logic rst,
                       input logic en, input logic rw,
                       input logic sel, input data_t a,
                       input data_t b, input reg_idx_t rd);
      exp_t e;
      exp_t o;
      @(negedge clk);
      reset          = rst;
      mem_en_ex      = en;
      mem_rw_ex      = rw;
      mem_mux_sel_ex = sel;
      ans_ex         = a;
      B_Bypass       = b;
      RW_ex          = rd;
      if (rst) begin
         e.data = '0;
         e.rw   = '0;
         for (int i = 0; i < DEPTH; i++) model[i] = '0;
      end else begin
         e.rw   = rd;
         e.data = sel ? (en ? model[a] : 8'h00) : a;
         if (en && rw) model[a] = b;
      end
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         chk({tag, "_sb_empty"}, 8'h01, 8'h00);
      end else begin
         o = sb_q.pop_front();
         chk({tag, "_data"}, mux_ans_dm, o.data);
         chk({tag, "_rw"}, {3'b000, RW_dm}, {3'b000, o.rw});
      end
   endtask

   initial begin
      step("reset", 1, 0, 0, 0, 8'h00, 8'h00, 5'h0A);
      step("rd_rst05", 0, 1, 0, 1, 8'h05, 8'h00, 5'h01);
      step("rd_rstFF", 0, 1, 0, 1, 8'hFF, 8'h00, 5'h02);
      step("disabled", 0, 0, 0, 1, 8'h05, 8'h00, 5'h1F);
      step("wr05_old", 0, 1, 1, 1, 8'h05, 8'h50, 5'h03);
      step("rd05", 0, 1, 0, 1, 8'h05, 8'h00, 5'h04);
      step("dis_after", 0, 0, 0, 1, 8'h05, 8'h00, 5'h05);
      step("alu05", 0, 1, 0, 0, 8'h05, 8'h00, 5'h06);
      step("aluA3", 0, 1, 0, 0, 8'hA3, 8'h00, 5'h07);
      step("wr00", 0, 1, 1, 1, 8'h00, 8'h11, 5'h08);
      step("wrFF", 0, 1, 1, 0, 8'hFF, 8'h22, 5'h09);
      step("rd00", 0, 1, 0, 1, 8'h00, 8'h00, 5'h0B);
      step("rdFF", 0, 1, 0, 1, 8'hFF, 8'h00, 5'h0C);
      step("rd05b", 0, 1, 0, 1, 8'h05, 8'h00, 5'h0D);
      step("wr05_rewr", 0, 1, 1, 1, 8'h05, 8'h66, 5'h0E);
      step("rd05c", 0, 1, 0, 1, 8'h05, 8'h00, 5'h0F);
      step("wr_dis", 0, 0, 1, 1, 8'h05, 8'h99, 5'h10);
      step("rd05d", 0, 1, 0, 1, 8'h05, 8'h00, 5'h11);
      step("rst_wr", 1, 1, 1, 1, 8'h05, 8'h77, 5'h12);
      step("rd05_rst", 0, 1, 0, 1, 8'h05, 8'h00, 5'h13);
      step("rd00_rst", 0, 1, 0, 1, 8'h00, 8'h00, 5'h14);
      for (int n = 0; n < 300; n++) begin
         logic  en;
         logic  rw;
         logic  sel;
         data_t a;
         a   = data_t'($urandom_range(0, 7));
         if ($urandom_range(0, 3) == 0) a = data_t'($urandom);
         en  = 1'($urandom);
         rw  = 1'($urandom);
         sel = 1'($urandom);
         step("rand", ($urandom_range(0, 60) == 0), en, rw, sel, a,
              data_t'($urandom), reg_idx_t'($urandom));
      end
      for (int i = 0; i < 16; i++) begin
         step("fill", 0, 1, 1, 0, data_t'(i * 17), data_t'(i + 1),
              reg_idx_t'(i));
      end
      step("rst_sweep", 1, 0, 0, 0, 8'h00, 8'h00, 5'h00);
      for (int i = 0; i < DEPTH; i++) begin
         step("sweep", 0, 1, 0, 1, data_t'(i), 8'h00, reg_idx_t'(i));
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
